axis_pixel_packer: RTL and testbench
====================================

Name: axis_pixel_packer

Overview:
Downstream neighbour of the bayer extractor. It takes the extracted single-channel AXI4-Stream, one pixel per beat, and packs C_PACK_NUM consecutive pixels into one wide word for the DMA/VDMA write path. Frame start (tuser) and line end (tlast) are preserved at word granularity. Partial words at line end or frame break are flushed, with valid lanes marked by tkeep.

Parameters:
C_PIXEL_WIDTH, 8, bits per pixel on the slave side
C_PACK_NUM, 4, pixels per output word; power of two, 2..8

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
s_axis_tdata  input  C_PIXEL_WIDTH  input pixel
s_axis_tuser  input  1  first pixel of frame
s_axis_tlast  input  1  last pixel of line
s_axis_tvalid  input  1  input valid
s_axis_tready  output  1  input ready
m_axis_tdata  output  C_PIXEL_WIDTH*C_PACK_NUM  packed word; first pixel in bits [C_PIXEL_WIDTH-1:0]
m_axis_tkeep  output  C_PACK_NUM  lane i valid = bit i; contiguous from bit 0
m_axis_tuser  output  1  word contains first pixel of frame
m_axis_tlast  output  1  word ends a line, or a frame was broken mid-word
m_axis_tvalid  output  1  output valid
m_axis_tready  input  1  output ready

Behaviour:
- Reset: clk is the only clock. reset is asynchronous and active-high. On reset, all of the following are cleared: m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, lane count, accumulator and sticky user flag. s_axis_tready is forced 0 while reset is high. Reset mid-word discards the partial word with no flush.
- Structure: accumulator (C_PACK_NUM-1 pixel lanes), lane count cnt (0..C_PACK_NUM-1), sticky acc_user, and one output register stage.
- Output stage: can load when out_free = ~m_axis_tvalid | m_axis_tready.
- s_axis_tready = out_free & ~break, where break = s_axis_tvalid & s_axis_tuser & (cnt != 0).
- Accepted pixel (s_axis_tvalid & s_axis_tready):
  - If cnt == C_PACK_NUM-1 or s_axis_tlast: load the output register.
    - tdata = accumulator lanes plus the incoming pixel in lane cnt; upper unused lanes are 0.
    - tkeep = (1 << (cnt+1)) - 1.
    - tuser = acc_user | (s_axis_tuser & cnt==0).
    - tlast = s_axis_tlast.
    - Then set cnt=0 and acc_user=0.
  - Otherwise: store the pixel in lane cnt, cnt+1, and acc_user |= s_axis_tuser (only possible at cnt==0).
- Break (tuser arriving while cnt != 0), when out_free: flush the partial word.
  - tkeep = (1<<cnt)-1, tlast=1, tuser=acc_user.
  - Clear cnt and acc_user. The tuser pixel is not consumed that cycle and is accepted on the next cycle.
- Latency: a word is valid on m_axis the cycle after the completing pixel handshake.
- Throughput: with m_axis_tready held at 1, one pixel is accepted per cycle with no bubbles. The only extra cycle is the break flush.
- Output hold: when m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* stay stable and s_axis_tready=0.
- m_axis_tvalid clears on handshake unless a new word loads in the same cycle (simultaneous unload and load keeps it at 1).
- s_axis_tlast with cnt==C_PACK_NUM-1 produces a single full word with tlast=1 (no empty word follows).
- C_PACK_NUM=1 is illegal. The block does not check for it.

Test Plan:
- Full-rate line: 10-pixel line, data 0x00..0x09, tuser on first pixel, tlast on the tenth, m_axis_tready=1 -> 3 words:
  - 0x03020100, tkeep=1111, tuser=1, tlast=0
  - 0x07060504, tkeep=1111, tuser=0, tlast=0
  - 0x00000908, tkeep=0011, tuser=0, tlast=1
  - s_axis_tready stays 1 throughout.
- Single-pixel line: one pixel 0xAB with tuser=1 and tlast=1 -> one word 0x000000AB, tkeep=0001, tuser=1, tlast=1, one cycle later.
- Backpressure: 8-pixel line with m_axis_tready toggled randomly -> identical words 0x03020100 then 0x07060504 (tlast=1); m_axis_* stable while stalled; no pixel lost or duplicated.
- Frame break: pixels 0x10, 0x11 (no tlast), then 0x20 with tuser -> word 0x00001110, tkeep=0011, tlast=1; s_axis_tready=0 for one cycle; next word starts with 0x20 and tuser=1.
- Reset mid-word: accept 3 pixels, assert reset -> m_axis_tvalid=0 and all outputs 0 immediately (asynchronous); after release, a 4-pixel line 0x30..0x33 gives exactly 0x33323130, tkeep=1111, with no stale lanes.
- Frame regression: 10x10 frame from the extractor's bench source at full rate -> 30 words; every third word has tkeep=0011 and tlast=1; only the first word has tuser=1.

Source files
------------

// File: rtl/axis_pixel_packer.sv
// rtl/axis_pixel_packer.sv - packs C_PACK_NUM single-channel pixels into one wide AXI-Stream word
//
// Purpose: collects consecutive pixels into an accumulator and emits a packed
// word when the word is full or the line ends. A tuser pixel arriving
// mid-word flushes the partial word first (tlast=1) so every frame starts on
// lane 0. tkeep marks valid lanes, contiguous from lane 0.
//
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   s_axis_t*            - one pixel per beat (tdata/tuser/tlast/tvalid/tready)
//   m_axis_t*            - packed word, first pixel in the low lane
//                          (tdata/tkeep/tuser/tlast/tvalid/tready)
module axis_pixel_packer #(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_PACK_NUM    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [C_PIXEL_WIDTH-1:0]        s_axis_tdata,
  input  logic                            s_axis_tuser,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [C_PIXEL_WIDTH*C_PACK_NUM-1:0] m_axis_tdata,
  output logic [C_PACK_NUM-1:0]           m_axis_tkeep,
  output logic                            m_axis_tuser,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready
);

  localparam int W  = C_PIXEL_WIDTH;
  localparam int N  = C_PACK_NUM;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_LANE = CW'(N - 1);

  logic [CW-1:0]      r_cnt;
  logic [(N-1)*W-1:0] r_acc;
  logic               r_acc_user;

  logic [N*W-1:0]     r_m_tdata;
  logic [N-1:0]       r_m_tkeep;
  logic               r_m_tuser;
  logic               r_m_tlast;
  logic               r_m_tvalid;

  logic               w_out_free;
  logic               w_break;
  logic               w_s_ready;
  logic               w_accept;
  logic               w_complete;
  logic               w_flush;
  logic [N*W-1:0]     w_acc_ext;
  logic [N*W-1:0]     w_word;
  logic [N-1:0]       w_keep;
  logic               w_user;
  logic               w_last;

  assign w_out_free = ~r_m_tvalid | m_axis_tready;
  // A new frame must start on lane 0: a tuser pixel seen with lanes pending
  // is held off while the partial word is flushed.
  assign w_break    = s_axis_tvalid & s_axis_tuser & (r_cnt != '0);
  assign w_s_ready  = w_out_free & ~w_break & ~reset;
  assign w_accept   = s_axis_tvalid & w_s_ready;
  assign w_complete = w_accept & ((r_cnt == LAST_LANE) | s_axis_tlast);
  assign w_flush    = w_break & w_out_free;

  // Pad the accumulator to a full word so every lane index is in range.
  assign w_acc_ext  = {{W{1'b0}}, r_acc};

  // Word assembly shared by the complete and flush paths: stored lanes below
  // cnt, the incoming pixel in lane cnt (complete only), zeros above.
  always_comb begin
    w_word = '0;
    w_keep = '0;
    for (int i = 0; i < N; i++) begin
      if (CW'(i) < r_cnt) begin
        w_word[i*W +: W] = w_acc_ext[i*W +: W];
        w_keep[i]        = 1'b1;
      end else if ((CW'(i) == r_cnt) && !w_break) begin
        w_word[i*W +: W] = s_axis_tdata;
        w_keep[i]        = 1'b1;
      end
    end
  end

  // On a flush cnt != 0, so the incoming tuser term drops out by itself.
  assign w_user = r_acc_user | (s_axis_tuser & (r_cnt == '0));
  assign w_last = w_break | s_axis_tlast;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_acc_user <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tuser  <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else begin
      if (w_complete || w_flush) begin
        r_m_tdata  <= w_word;
        r_m_tkeep  <= w_keep;
        r_m_tuser  <= w_user;
        r_m_tlast  <= w_last;
        r_m_tvalid <= 1'b1;
        r_cnt      <= '0;
        r_acc_user <= 1'b0;
      end else begin
        if (m_axis_tready) begin
          r_m_tvalid <= 1'b0;
        end
        if (w_accept) begin
          r_cnt      <= r_cnt + 1'b1;
          r_acc_user <= r_acc_user | s_axis_tuser;
          for (int i = 0; i < N - 1; i++) begin
            if (r_cnt == CW'(i)) begin
              r_acc[i*W +: W] <= s_axis_tdata;
            end
          end
        end
      end
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tkeep  = r_m_tkeep;
  assign m_axis_tuser  = r_m_tuser;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tvalid = r_m_tvalid;

endmodule

// File: tb/tb_axis_pixel_packer.sv
// tb/tb_axis_pixel_packer.sv - self-checking bench for axis_pixel_packer
module tb_axis_pixel_packer;

  localparam int P = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [P-1:0]   s_tdata;
  logic           s_tuser, s_tlast, s_tvalid, s_tready;
  logic [P*N-1:0] m_tdata;
  logic [N-1:0]   m_tkeep;
  logic           m_tuser, m_tlast, m_tvalid, m_tready;

  axis_pixel_packer #(.C_PIXEL_WIDTH(P), .C_PACK_NUM(N)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [P*N-1:0] d;
    logic [N-1:0]   k;
    logic           u;
    logic           l;
  } word_t;

  int checks = 0;
  int errors = 0;

  logic [P-1:0] px_d[$];
  bit           px_u[$];
  bit           px_l[$];
  word_t        exp_q[$];
  int           exp_breaks;
  int           words_rx;
  int           users_rx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: group pixels into words; a tuser pixel closes any open group
  // as a tlast word, a group closes when full or on a line end.
  task automatic emit(inout logic [P-1:0] g[$], inout bit gu, input bit last);
    word_t w;
    w.d = '0;
    foreach (g[i]) w.d = w.d | ({{(P*N-P){1'b0}}, g[i]} << (P*i));
    w.k = N'((1 << g.size()) - 1);
    w.u = gu;
    w.l = last;
    exp_q.push_back(w);
    g.delete();
    gu = 0;
  endtask

  task automatic build_model();
    logic [P-1:0] g[$];
    bit gu;
    gu = 0;
    exp_q.delete();
    exp_breaks = 0;
    for (int k = 0; k < px_d.size(); k++) begin
      if (px_u[k] && g.size() != 0) begin
        emit(g, gu, 1'b1);
        exp_breaks++;
      end
      g.push_back(px_d[k]);
      gu = gu | px_u[k];
      if (g.size() == N || px_l[k]) emit(g, gu, px_l[k]);
    end
  endtask

  task automatic clear_px();
    px_d.delete(); px_u.delete(); px_l.delete();
  endtask

  task automatic add_px(input logic [P-1:0] d, input bit u, input bit l);
    px_d.push_back(d); px_u.push_back(u); px_l.push_back(l);
  endtask

  task automatic run_stream(input string name, input bit rdy_rand, input bit vld_rand);
    int idx, cycles, stalls, limit;
    bit prev_stall;
    logic [P*N+N+2:0] prev, cur;
    word_t w;
    build_model();
    idx = 0; cycles = 0; stalls = 0; prev_stall = 0; prev = '0;
    words_rx = 0; users_rx = 0;
    limit = px_d.size() * 20 + 50;
    while ((idx < px_d.size() || exp_q.size() > 0) && cycles < limit) begin
      @(posedge clk); #1;
      s_tvalid = (idx < px_d.size()) && (!vld_rand || ($urandom_range(0, 3) != 0));
      if (idx < px_d.size()) begin
        s_tdata = px_d[idx]; s_tuser = px_u[idx]; s_tlast = px_l[idx];
      end
      m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cur = {m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast};
      if (prev_stall) chk({name, "_hold_stable"}, cur, prev);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk({name, "_extra_word"}, 1, 0);
        end else begin
          w = exp_q.pop_front();
          chk({name, "_tdata"}, m_tdata, w.d);
          chk({name, "_tkeep"}, m_tkeep, w.k);
          chk({name, "_tuser"}, m_tuser, w.u);
          chk({name, "_tlast"}, m_tlast, w.l);
          words_rx++;
          if (m_tuser) users_rx++;
        end
      end
      if (s_tvalid && !s_tready) stalls++;
      if (s_tvalid && s_tready) idx++;
      prev_stall = m_tvalid && !m_tready;
      prev = cur;
      cycles++;
    end
    chk({name, "_completed_in_budget"}, cycles < limit, 1);
    if (!rdy_rand && !vld_rand) chk({name, "_s_ready_gaps"}, stalls, exp_breaks);
    @(posedge clk); #1;
    s_tvalid = 0; s_tuser = 0; s_tlast = 0; m_tready = 1;
  endtask

  initial begin
    reset = 1; s_tdata = 8'h5A; s_tuser = 1; s_tlast = 0; s_tvalid = 1; m_tready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast}, 0);
    chk("reset_s_ready", s_tready, 0);
    s_tvalid = 0; s_tuser = 0;
    reset = 0;

    // full-rate 10-pixel line
    clear_px();
    for (int i = 0; i < 10; i++) add_px(P'(i), i == 0, i == 9);
    run_stream("line10", 0, 0);
    chk("line10_words", words_rx, 3);

    // single pixel line, one-cycle latency
    @(posedge clk); #1;
    s_tvalid = 1; s_tdata = 8'hAB; s_tuser = 1; s_tlast = 1; m_tready = 1;
    @(negedge clk);
    chk("single_accept", {s_tready, m_tvalid}, 2'b10);
    @(posedge clk); #1;
    s_tvalid = 0; s_tuser = 0; s_tlast = 0;
    @(negedge clk);
    chk("single_word", {m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast}, {1'b1, 32'h000000AB, 4'b0001, 1'b1, 1'b1});
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_valid_clears", m_tvalid, 0);

    // backpressure, 8-pixel line
    clear_px();
    for (int i = 0; i < 8; i++) add_px(P'(i), i == 0, i == 7);
    run_stream("bp8", 1, 0);
    chk("bp8_words", words_rx, 2);

    // frame break mid-word
    clear_px();
    add_px(8'h10, 1, 0); add_px(8'h11, 0, 0); add_px(8'h20, 1, 0); add_px(8'h21, 0, 1);
    run_stream("break", 0, 0);
    chk("break_words", words_rx, 2);

    // reset with a partial word pending
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      s_tvalid = 1; s_tdata = P'(8'h40 + k); s_tuser = (k == 0); s_tlast = 0;
    end
    @(posedge clk); #1;
    s_tvalid = 0; s_tuser = 0;
    reset = 1;
    #1;
    chk("rst_mid_outputs", {m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast}, 0);
    chk("rst_mid_s_ready", s_tready, 0);
    @(posedge clk); #1;
    reset = 0;
    clear_px();
    for (int i = 0; i < 4; i++) add_px(P'(8'h30 + i), i == 0, i == 3);
    run_stream("post_rst", 0, 0);
    chk("post_rst_words", words_rx, 1);

    // reset while a word is held by backpressure clears it asynchronously
    @(posedge clk); #1;
    m_tready = 0; s_tvalid = 1; s_tdata = 8'h55; s_tuser = 1; s_tlast = 1;
    @(posedge clk); #1;
    s_tvalid = 0; s_tuser = 0; s_tlast = 0;
    @(negedge clk);
    chk("held_valid", {m_tvalid, s_tready}, 2'b10);
    #2;
    reset = 1;
    #1;
    chk("rst_held_outputs", {m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast}, 0);
    @(posedge clk); #1;
    reset = 0; m_tready = 1;

    // 10x10 frame at full rate
    clear_px();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        add_px(P'($urandom), (r == 0 && c == 0), c == 9);
    run_stream("frame", 0, 0);
    chk("frame_words", words_rx, 30);
    chk("frame_user_words", users_rx, 1);

    // randomized frames: random line lengths, stray mid-line frame starts,
    // random valid gaps and backpressure
    for (int f = 0; f < 4; f++) begin
      clear_px();
      for (int r = 0; r < 6; r++) begin
        int len;
        len = $urandom_range(1, 13);
        for (int c = 0; c < len; c++)
          add_px(P'($urandom), (r == 0 && c == 0) || ($urandom_range(0, 19) == 0), c == len - 1);
      end
      run_stream("random", 1, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
